// File: rtl/cpu_pkg.sv
// cpu_pkg: next-PC select encodings and fetch constants shared by the pipeline.
package cpu_pkg;
   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JR  = 2'b10,
      PCSRC_J   = 2'b11
   } pcsrc_e;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pipe_if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush loads a bubble even while stalled.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] pc4_i,
   input  logic [31:0] inst_i,
   output logic [31:0] pc4_o,
   output logic [31:0] inst_o,
   output logic        valid_o
);
   logic [31:0] pc4_q, inst_q;
   logic        valid_q;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pc4_q   <= 32'h0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else if (!stall) begin
         pc4_q   <= pc4_i;
         inst_q  <= inst_i;
         valid_q <= 1'b1;
      end
   end
   assign pc4_o   = pc4_q;
   assign inst_o  = inst_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/pipe_if_stage.sv
// pipe_if_stage: PC register, next-PC mux and IF/ID capture with delayed-branch semantics.
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  pcsrc,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        id_valid,
   output logic        fetch_err
);
   import cpu_pkg::*;
   logic [31:0] pc_q, pc_d, pc4, tgt;
   logic        err_q, err_d;
   always_comb begin
      pc4   = pc_q + 32'd4;
      tgt   = pcsrc == PCSRC_BR ? bpc :
              pcsrc == PCSRC_JR ? rpc :
              pcsrc == PCSRC_J  ? jpc : pc4;
      // pcsrc is ignored while stalled; ID reasserts it afterwards
      pc_d  = stall ? pc_q : {tgt[31:2], 2'b00};
      err_d = err_q | (!stall && tgt[1:0] != 2'b00);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end
   if_id_reg u_if_id (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .flush   (flush),
      .pc4_i   (pc4),
      .inst_i  (imem_inst),
      .pc4_o   (id_pc4),
      .inst_o  (id_inst),
      .valid_o (id_valid)
   );
   assign imem_addr = pc_q;
   assign fetch_err = err_q;
endmodule

// File: tb/tb_pipe_if_stage.sv
// tb_pipe_if_stage: directed test-plan sequences plus random traffic, scoreboarded against a reference model.
module tb_pipe_if_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [1:0]  pcsrc = 2'b00;
   logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0;
   logic [31:0] imem_addr, imem_inst, id_pc4, id_inst;
   logic        id_valid, fetch_err;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        valid;
      logic        err;
   } obs_t;

   obs_t q[$];
   obs_t m, mon_e, mon_g;
   int   checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign imem_inst = rom(imem_addr);

   pipe_if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pcsrc(pcsrc),
      .bpc(bpc), .rpc(rpc), .jpc(jpc), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid), .fetch_err(fetch_err)
   );

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         mon_g = '{imem_addr, id_pc4, id_inst, id_valid, fetch_err};
         checks++;
         if (mon_g !== mon_e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got addr=%h pc4=%h inst=%h v=%b err=%b exp addr=%h pc4=%h inst=%h v=%b err=%b",
                     $time, mon_g.addr, mon_g.pc4, mon_g.inst, mon_g.valid, mon_g.err,
                     mon_e.addr, mon_e.pc4, mon_e.inst, mon_e.valid, mon_e.err);
         end
      end
   end

   // one clock of stimulus; expected post-edge state comes from the fetch rules
   task automatic cyc(input logic r, input logic s, input logic f, input logic [1:0] p,
                      input logic [31:0] b, input logic [31:0] rp, input logic [31:0] j);
      logic [31:0] t;
      obs_t n;
      rst = r; stall = s; flush = f; pcsrc = p; bpc = b; rpc = rp; jpc = j;
      n = m;
      if (r) n = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
      else begin
         case (p)
            2'd1: t = b;
            2'd2: t = rp;
            2'd3: t = j;
            default: t = m.addr + 32'd4;
         endcase
         if (f) begin n.pc4 = 0; n.inst = 0; n.valid = 0; end
         else if (!s) begin n.pc4 = m.addr + 32'd4; n.inst = rom(m.addr); n.valid = 1; end
         if (!s) begin
            n.addr = t & 32'hFFFF_FFFC;
            if (t[1:0] != 2'b00) n.err = 1'b1;
         end
      end
      m = n;
      @(posedge clk);
      q.push_back(n);
      #1;
   endtask

   task automatic free();
      cyc(0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   initial begin
      cyc(1, 0, 0, 2'd0, 0, 0, 0);
      chk("reset_addr", imem_addr, 32'h0);
      chk("reset_valid", {31'h0, id_valid}, 32'h0);
      free();
      chk("run1_inst", id_inst, 32'h1000_0000);
      chk("run1_pc4", id_pc4, 32'h4);
      chk("run1_valid", {31'h0, id_valid}, 32'h1);
      free();
      chk("run2_addr", imem_addr, 32'h8);
      chk("run2_inst", id_inst, 32'h1000_0001);
      free();
      chk("run3_addr", imem_addr, 32'hC);
      cyc(0, 0, 0, 2'd3, 0, 0, 32'h1C);
      chk("jump_addr", imem_addr, 32'h1C);
      chk("delay_inst", id_inst, 32'h1000_0003);
      chk("delay_pc4", id_pc4, 32'h10);
      free();
      chk("jump_next", imem_addr, 32'h20);
      cyc(0, 0, 0, 2'd3, 0, 0, 32'h10);
      free();
      free();
      chk("pre_branch", imem_addr, 32'h18);
      cyc(0, 0, 0, 2'd1, 32'h8, 0, 0);
      chk("branch0", imem_addr, 32'h8);
      for (int k = 0; k < 3; k++) begin
         repeat (4) free();
         chk("loop_tail", imem_addr, 32'h18);
         cyc(0, 0, 0, 2'd1, 32'h8, 0, 0);
         chk("loop_head", imem_addr, 32'h8);
      end
      cyc(0, 0, 0, 2'd2, 0, 32'h0000_0012, 0);
      chk("jr_addr", imem_addr, 32'h10);
      chk("jr_err", {31'h0, fetch_err}, 32'h1);
      cyc(0, 0, 0, 2'd3, 0, 0, 32'h1C);
      chk("err_sticky", {31'h0, fetch_err}, 32'h1);
      repeat (3) cyc(0, 1, 0, 2'd3, 0, 0, 32'h40);
      chk("stall_addr", imem_addr, 32'h1C);
      chk("stall_pc4", id_pc4, 32'h14);
      free();
      chk("resume_addr", imem_addr, 32'h20);
      chk("resume_pc4", id_pc4, 32'h20);
      chk("resume_inst", id_inst, 32'h1000_0007);
      cyc(0, 1, 1, 2'd0, 0, 0, 0);
      chk("sf_addr", imem_addr, 32'h20);
      chk("sf_inst", id_inst, 32'h0);
      chk("sf_valid", {31'h0, id_valid}, 32'h0);
      cyc(0, 0, 0, 2'd3, 0, 0, 32'hFFFF_FFFC);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(1, 0, 0, 2'd3, 0, 0, 32'h40);
      chk("rst_mid_addr", imem_addr, 32'h0);
      chk("rst_mid_valid", {31'h0, id_valid}, 32'h0);
      chk("rst_mid_err", {31'h0, fetch_err}, 32'h0);
      free();
      cyc(0, 0, 0, 2'd3, 0, 0, 32'hFFFF_FFFC);
      free();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc4", id_pc4, 32'h0);
      chk("wrap_err", {31'h0, fetch_err}, 32'h0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] b, rp, j;
         b  = $urandom_range(0, 15) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
         rp = $urandom_range(0, 15) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
         j  = $urandom_range(0, 15) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
         cyc($urandom_range(0, 40) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
             2'($urandom_range(0, 3)), b, rp, j);
      end
      free();
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
